// File: rtl/control_unit_pkg.sv
// Shared definitions for the multi-cycle control unit: widths, IR field
// positions, opcode and ALU codes, and the FSM state encoding.
// Optional feature macro: CU_STEP_EN (adds the STEP_WAIT single-step state).
package control_unit_pkg;

  localparam int REG_SIZE = 32;
  localparam int NUM_GPR  = 16;

  // IR field positions: op[31:27] ra[26:23] rb[22:19] rc[18:15]
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int RA_LSB = 23;
  localparam int RB_LSB = 19;
  localparam int RC_LSB = 15;
  localparam int RF_W   = 4;

  localparam logic [4:0] OP_ADD      = 5'd0;
  localparam logic [4:0] OP_LAST_ALU = 5'd11;
  localparam logic [4:0] OP_MUL      = 5'd12;
  localparam logic [4:0] OP_DIV      = 5'd13;
  localparam logic [4:0] OP_HALT     = 5'd31;

  localparam logic [3:0] ALU_ADD = 4'd0;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_F0      = 4'd1,
    S_F1      = 4'd2,   // first memory-wait cycle, PC is loaded here
    S_F1_WAIT = 4'd3,   // further memory-wait cycles until ack
    S_F2      = 4'd4,
    S_DEC     = 4'd5,
    S_E0      = 4'd6,
    S_E1      = 4'd7,
    S_E2      = 4'd8,
    S_E3      = 4'd9,
    S_HALT    = 4'd10,
    S_ILL     = 4'd11
`ifdef CU_STEP_EN
    , S_STEP_WAIT = 4'd12
`endif
  } state_t;

  // Register-register ALU opcodes occupy 0..11
  function automatic logic is_alu_op(input logic [4:0] op);
    return op <= OP_LAST_ALU;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control/handshake bundle between the control unit (master) and the bus
// datapath plus memory interface (slave).
interface control_unit_if;
  import control_unit_pkg::*;

  logic [REG_SIZE-1:0] ir_data;
  logic                mem_ack;
  logic                mem_req;
  logic                read;
  logic [NUM_GPR-1:0]  gpr_in;
  logic [NUM_GPR-1:0]  gpr_out;
  logic hi_in, lo_in, pc_in, ir_in, z_in, y_in, mar_in, mdr_in;
  logic hi_out, lo_out, pc_out, z_high_out, z_low_out, mdr_out;
  logic inport_out, c_out;
  logic [3:0]          alu_op;
  logic                inc_pc;

  modport master (
    input  ir_data, mem_ack,
    output mem_req, read, gpr_in, gpr_out,
    output hi_in, lo_in, pc_in, ir_in, z_in, y_in, mar_in, mdr_in,
    output hi_out, lo_out, pc_out, z_high_out, z_low_out, mdr_out,
    output inport_out, c_out, alu_op, inc_pc
  );

  modport slave (
    output ir_data, mem_ack,
    input  mem_req, read, gpr_in, gpr_out,
    input  hi_in, lo_in, pc_in, ir_in, z_in, y_in, mar_in, mdr_in,
    input  hi_out, lo_out, pc_out, z_high_out, z_low_out, mdr_out,
    input  inport_out, c_out, alu_op, inc_pc
  );

endinterface

// File: rtl/control_unit_ir_field_decode.sv
// Combinational IR field decoder: opcode class flags, ALU code and one-hot
// register selects for ra/rb/rc.
module ir_field_decode
  import control_unit_pkg::*;
(
  input  logic [REG_SIZE-1:0] ir_data,
  output logic [3:0]          alu_code,
  output logic                alu_class,
  output logic                muldiv,
  output logic                halt_op,
  output logic [NUM_GPR-1:0]  ra_sel,
  output logic [NUM_GPR-1:0]  rb_sel,
  output logic [NUM_GPR-1:0]  rc_sel
);

  logic [4:0]      op;
  logic [RF_W-1:0] ra, rb, rc;
  logic [RC_LSB-1:0] unused_low;

  assign op         = ir_data[OP_MSB:OP_LSB];
  assign ra         = ir_data[RA_LSB+RF_W-1:RA_LSB];
  assign rb         = ir_data[RB_LSB+RF_W-1:RB_LSB];
  assign rc         = ir_data[RC_LSB+RF_W-1:RC_LSB];
  assign unused_low = ir_data[RC_LSB-1:0];

  assign alu_code  = op[3:0];
  assign alu_class = is_alu_op(op);
  assign muldiv    = (op == OP_MUL) || (op == OP_DIV);
  assign halt_op   = (op == OP_HALT);

  // 4->16 one-hot decoders for the three register fields
  generate
    for (genvar gi = 0; gi < NUM_GPR; gi++) begin : g_sel
      assign ra_sel[gi] = (ra == RF_W'(gi));
      assign rb_sel[gi] = (rb == RF_W'(gi));
      assign rc_sel[gi] = (rc == RF_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/control_unit.sv
// Hardwired multi-cycle control unit: fetch / decode / execute sequencing of
// register-register ALU, MUL and DIV instructions on a single 32-bit bus.
// Optional feature macro: CU_STEP_EN (single-step via edge-detected step).
module control_unit
  import control_unit_pkg::*;
(
  input  logic           clk,
  input  logic           reset_n,
  input  logic           run,
  input  logic           step,
  control_unit_if.master bus,
  output logic           halted,
  output logic           illegal
);

  state_t state_reg, state_next;
  state_t start_state, after_instr;
  logic   illegal_reg;

  logic [3:0]         alu_code;
  logic               alu_class, muldiv, halt_op;
  logic [NUM_GPR-1:0] ra_sel, rb_sel, rc_sel;

  ir_field_decode u_decode (
    .ir_data   (bus.ir_data),
    .alu_code  (alu_code),
    .alu_class (alu_class),
    .muldiv    (muldiv),
    .halt_op   (halt_op),
    .ra_sel    (ra_sel),
    .rb_sel    (rb_sel),
    .rc_sel    (rc_sel)
  );

`ifdef CU_STEP_EN
  logic step_prev_reg;
  logic step_rise;

  // Remember last step level so a held step advances only once
  always_ff @(posedge clk) begin
    if (!reset_n) step_prev_reg <= 1'b0;
    else          step_prev_reg <= step;
  end

  assign step_rise   = step & ~step_prev_reg;
  assign start_state = S_STEP_WAIT;
  assign after_instr = run ? S_STEP_WAIT : S_IDLE;
`else
  logic unused_step;
  assign unused_step = step;
  assign start_state = S_F0;
  assign after_instr = run ? S_F0 : S_IDLE;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state_reg <= S_IDLE;
    else          state_reg <= state_next;
  end

  // Sticky illegal-opcode flag, set while passing through ILL
  always_ff @(posedge clk) begin
    if (!reset_n)                illegal_reg <= 1'b0;
    else if (state_reg == S_ILL) illegal_reg <= 1'b1;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:    if (run) state_next = start_state;
      S_F0:      state_next = S_F1;
      S_F1,
      S_F1_WAIT: state_next = bus.mem_ack ? S_F2 : S_F1_WAIT;
      S_F2:      state_next = S_DEC;
      S_DEC: begin
        if (alu_class || muldiv) state_next = S_E0;
        else if (halt_op)        state_next = S_HALT;
        else                     state_next = S_ILL;
      end
      S_E0:      state_next = S_E1;
      S_E1:      state_next = S_E2;
      S_E2:      state_next = alu_class ? after_instr : S_E3;
      S_E3:      state_next = after_instr;
      S_HALT:    state_next = S_HALT;
      S_ILL:     state_next = S_HALT;
`ifdef CU_STEP_EN
      S_STEP_WAIT: begin
        if (!run)           state_next = S_IDLE;
        else if (step_rise) state_next = S_F0;
      end
`endif
      default:   state_next = S_IDLE;
    endcase
  end

  // Control outputs decoded from the state (mdr_in also qualified by ack)
  always_comb begin
    bus.mem_req    = 1'b0;
    bus.read       = 1'b0;
    bus.gpr_in     = '0;
    bus.gpr_out    = '0;
    bus.hi_in      = 1'b0;
    bus.lo_in      = 1'b0;
    bus.pc_in      = 1'b0;
    bus.ir_in      = 1'b0;
    bus.z_in       = 1'b0;
    bus.y_in       = 1'b0;
    bus.mar_in     = 1'b0;
    bus.mdr_in     = 1'b0;
    bus.hi_out     = 1'b0;
    bus.lo_out     = 1'b0;
    bus.pc_out     = 1'b0;
    bus.z_high_out = 1'b0;
    bus.z_low_out  = 1'b0;
    bus.mdr_out    = 1'b0;
    bus.alu_op     = ALU_ADD;
    bus.inc_pc     = 1'b0;
    case (state_reg)
      S_F0: begin
        bus.pc_out = 1'b1;
        bus.mar_in = 1'b1;
        bus.inc_pc = 1'b1;
        bus.z_in   = 1'b1;
        bus.alu_op = ALU_ADD;
      end
      S_F1, S_F1_WAIT: begin
        bus.mem_req   = 1'b1;
        bus.read      = 1'b1;
        bus.z_low_out = 1'b1;
        bus.pc_in     = (state_reg == S_F1);
        bus.mdr_in    = bus.mem_ack;
      end
      S_F2: begin
        bus.mdr_out = 1'b1;
        bus.ir_in   = 1'b1;
      end
      S_E0: begin
        bus.gpr_out = rb_sel;
        bus.y_in    = 1'b1;
      end
      S_E1: begin
        bus.gpr_out = rc_sel;
        bus.alu_op  = alu_code;
        bus.z_in    = 1'b1;
      end
      S_E2: begin
        bus.z_low_out = 1'b1;
        if (alu_class) bus.gpr_in = ra_sel;
        else           bus.lo_in  = 1'b1;
      end
      S_E3: begin
        bus.z_high_out = 1'b1;
        bus.hi_in      = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.inport_out = 1'b0;
  assign bus.c_out      = 1'b0;

`ifdef CU_STEP_EN
  assign halted = (state_reg == S_IDLE) || (state_reg == S_HALT) ||
                  (state_reg == S_STEP_WAIT);
`else
  assign halted = (state_reg == S_IDLE) || (state_reg == S_HALT);
`endif
  assign illegal = illegal_reg;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-instruction expectations are
// queued when an instruction is issued and popped as the FSM reaches E0/E1/E2.
module tb_control_unit;
  import control_unit_pkg::*;

  logic clk = 1'b0;
  logic reset_n, run, step;
  logic halted, illegal;

  control_unit_if bus ();

  control_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (run),
    .step    (step),
    .bus     (bus),
    .halted  (halted),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_y_q[$];
  logic [19:0] exp_e1_q[$];   // {alu_op, gpr_out}
  logic [15:0] exp_wb_q[$];

  logic [54:0] ctrl_all;
  logic [23:0] sel_all;
  assign ctrl_all = {bus.mem_req, bus.read, bus.inc_pc, bus.gpr_in, bus.gpr_out,
                     bus.hi_in, bus.lo_in, bus.pc_in, bus.ir_in, bus.z_in, bus.y_in,
                     bus.mar_in, bus.mdr_in, bus.hi_out, bus.lo_out, bus.pc_out,
                     bus.z_high_out, bus.z_low_out, bus.mdr_out, bus.inport_out,
                     bus.c_out, bus.alu_op};
  assign sel_all  = {bus.gpr_out, bus.hi_out, bus.lo_out, bus.pc_out, bus.z_high_out,
                     bus.z_low_out, bus.mdr_out, bus.inport_out, bus.c_out};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input int op, input int ra, input int rb, input int rc);
    logic [31:0] w;
    w        = '0;
    w[31:27] = op[4:0];
    w[26:23] = ra[3:0];
    w[22:19] = rb[3:0];
    w[18:15] = rc[3:0];
    return w;
  endfunction

  // Issue one instruction starting at the next F0, ack after ack_dly wait cycles
  task automatic do_instr(input logic [31:0] instr, input int ack_dly, input bit drop_run);
    int  op, ra, rb, rc, exp_cyc, exp_gin;
    int  cyc, req, pcin, mdr, gin;
    bit  ex, md, started, done;
    logic [3:0] aop;
    op  = int'(instr[31:27]);
    ra  = int'(instr[26:23]);
    rb  = int'(instr[22:19]);
    rc  = int'(instr[18:15]);
    aop = instr[30:27];
    ex  = (op <= 13);
    md  = (op == 12) || (op == 13);
    if (op <= 11)     exp_cyc = 7 + ack_dly;
    else if (md)      exp_cyc = 8 + ack_dly;
    else if (op == 31) exp_cyc = 5 + ack_dly;
    else              exp_cyc = 6 + ack_dly;
    exp_gin = (ex && !md) ? 1 : 0;
    if (ex) begin
      exp_y_q.push_back(16'h1 << rb);
      exp_e1_q.push_back({aop, 16'h1 << rc});
      exp_wb_q.push_back(md ? 16'h0 : (16'h1 << ra));
    end
    cyc = 0; req = 0; pcin = 0; mdr = 0; gin = 0;
    started = 1'b0; done = 1'b0;
    for (int t = 0; t < 60 && !done; t++) begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (!started && bus.pc_out && bus.mar_in) begin
        started = 1'b1;
        check("f0_ctrl", {26'd0, bus.inc_pc, bus.z_in, bus.alu_op}, {26'd0, 1'b1, 1'b1, 4'h0});
      end
      if (started) begin
        cyc++;
        if (bus.mem_req) begin
          if (req == 0) bus.ir_data = instr;
          if (req == ack_dly) bus.mem_ack = 1'b1;
          req++;
        end
        #1;
        if ($countones(sel_all) > 1) check("one_bus_sel", 32'($countones(sel_all)), 32'd1);
        if (bus.mem_req !== bus.read) check("read_eq_req", 32'(bus.read), 32'(bus.mem_req));
        if (bus.mdr_in) begin
          mdr++;
          check("mdr_in_at_ack", 32'(bus.mem_ack), 32'd1);
        end
        if (bus.pc_in) pcin++;
        if (|bus.gpr_in) gin++;
        if (bus.y_in) begin
          if (exp_y_q.size() == 0) check("y_in_unexpected", 32'd1, 32'd0);
          else check("e0_gpr_out", 32'(bus.gpr_out), 32'(exp_y_q.pop_front()));
        end
        if (bus.z_in && !bus.inc_pc) begin
          if (exp_e1_q.size() == 0) check("e1_unexpected", 32'd1, 32'd0);
          else check("e1_aluop_gpr_out", 32'({bus.alu_op, bus.gpr_out}), 32'(exp_e1_q.pop_front()));
          if (drop_run) run = 1'b0;
        end
        if (bus.z_low_out && !bus.mem_req) begin
          if (exp_wb_q.size() == 0) check("e2_unexpected", 32'd1, 32'd0);
          else check("e2_gpr_in", 32'(bus.gpr_in), 32'(exp_wb_q.pop_front()));
          check("e2_lo_in", 32'(bus.lo_in), 32'(md));
          if (!md) done = 1'b1;
        end
        if (bus.hi_in) begin
          check("e3_z_high_out", 32'(bus.z_high_out), 32'd1);
          done = 1'b1;
        end
        if (halted) done = 1'b1;
      end
    end
    bus.mem_ack = 1'b0;
    check("instr_done", 32'(done), 32'd1);
    check("cycles", 32'(cyc), 32'(exp_cyc));
    check("pc_in_once", 32'(pcin), 32'd1);
    check("mem_req_cycles", 32'(req), 32'(ack_dly + 1));
    check("mdr_in_once", 32'(mdr), 32'd1);
    check("gpr_in_pulses", 32'(gin), 32'(exp_gin));
    if (!ex) begin
      check("illegal_flag", 32'(illegal), 32'(op != 31));
      check("halted_flag", 32'(halted), 32'd1);
    end
    exp_y_q.delete();
    exp_e1_q.delete();
    exp_wb_q.delete();
    $display("instr 0x%08h op=%0d ack_dly=%0d cycles=%0d halted=%0b illegal=%0b",
             instr, op, ack_dly, cyc, halted, illegal);
  endtask

  task automatic apply_reset(input int n);
    reset_n = 1'b0;
    repeat (n) @(negedge clk);
    check("rst_ctrl_ones", 32'($countones(ctrl_all)), 32'd0);
    check("rst_halted", 32'(halted), 32'd1);
    check("rst_illegal", 32'(illegal), 32'd0);
    $display("reset held %0d cycles", n);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n     = 1'b0;
    run         = 1'b1;
    step        = 1'b0;
    bus.mem_ack = 1'b0;
    bus.ir_data = '0;
    apply_reset(3);

`ifdef CU_STEP_EN
    begin
      int f0_cnt;
      f0_cnt = 0;
      bus.ir_data = enc(0, 3, 1, 2);
      for (int t = 0; t < 40; t++) begin
        @(negedge clk);
        bus.mem_ack = bus.mem_req;
        step = (t >= 5 && t < 15);
        if (bus.pc_out && bus.mar_in) f0_cnt++;
        if (t == 4) begin
          check("step_no_f0_before", 32'(f0_cnt), 32'd0);
          check("step_wait_halted", 32'(halted), 32'd1);
        end
      end
      bus.mem_ack = 1'b0;
      check("step_one_instr", 32'(f0_cnt), 32'd1);
      check("step_halted_after", 32'(halted), 32'd1);
      $display("step held 10 cycles: %0d instruction(s) started", f0_cnt);
    end
`else
    do_instr(enc(0, 3, 1, 2), 0, 1'b0);     // ADD r3,r1,r2
    do_instr(enc(5, 7, 7, 7), 4, 1'b0);     // ra==rb==rc, slow memory
    do_instr(enc(12, 2, 4, 9), 0, 1'b0);    // MUL
    do_instr(enc(13, 6, 15, 0), 2, 1'b0);   // DIV
    do_instr(enc(11, 15, 0, 14), 1, 1'b1);  // run dropped in E1
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      check("idle_after_run0", 32'({halted, bus.pc_out}), 32'b10);
    end
    run = 1'b1;
    do_instr(enc(3, 1, 2, 3), 0, 1'b0);     // resumes from IDLE
    do_instr(enc(20, 1, 1, 1), 0, 1'b0);    // undefined opcode
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      check("ill_stays_halted", 32'({halted, illegal, bus.pc_out}), 32'b110);
    end
    apply_reset(2);
    do_instr(enc(31, 0, 0, 0), 3, 1'b0);    // HALT
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      check("halt_absorbing", 32'({halted, illegal, bus.pc_out}), 32'b100);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
